// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// hazard_fwd_unit: ALU operand forwarding plus load-use / mult-div stall control.
// Optional stall statistics counter (stall_count) when HAZARD_STALL_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module hazard_fwd_unit #(
  parameter int MD_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_reg_write,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic       md_start,
  input  logic       id_md_read,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall,
  output logic       id_ex_flush,
  output logic       md_busy
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int c_cnt_w = $clog2(MD_LATENCY);
  localparam logic [c_cnt_w-1:0] c_md_load = c_cnt_w'(MD_LATENCY - 1);
  localparam logic [c_cnt_w-1:0] c_md_last = c_cnt_w'(1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_md_cnt;
  logic [c_cnt_w-1:0] w_md_cnt_nxt;
  logic               w_load_use;
  logic               w_md_hazard;

  // EX/MEM is checked first so the youngest producer wins; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (ex_mem_reg_write && (ex_mem_rd != 5'd0) && (ex_mem_rd == src))
      return 2'd1;
    else if (mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == src))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  assign fwd_a_sel = fwd_sel(ex_rs);
  assign fwd_b_sel = fwd_sel(ex_rt);

  assign w_load_use  = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));
  assign md_busy     = (r_state == S_MD_BUSY);
  assign w_md_hazard = md_busy && id_md_read;
  assign stall       = w_load_use || w_md_hazard;
  assign id_ex_flush = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // md_start is only sampled in IDLE; the flush path has no influence on the count.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      S_IDLE: begin
        if (md_start) begin
          w_state_nxt  = S_MD_BUSY;
          w_md_cnt_nxt = c_md_load;
        end
      end
      S_MD_BUSY: begin
        w_md_cnt_nxt = r_md_cnt - 1'b1;
        if (r_md_cnt == c_md_last)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_count <= '0;
    else if (stall)
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_fwd_unit: directed plus randomized checks against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_hazard_fwd_unit;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_mem_rd, mem_wb_rd, id_ex_rt;
  logic       ex_mem_reg_write, mem_wb_reg_write, id_ex_mem_read, md_start, id_md_read;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, id_ex_flush, md_busy;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_count;
`endif

  int          checks = 0;
  int          failures = 0;
  int          md_left = 0;       // remaining busy cycles in the reference model
  int unsigned exp_cnt = 0;

  hazard_fwd_unit #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .md_start(md_start), .id_md_read(id_md_read),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .id_ex_flush(id_ex_flush), .md_busy(md_busy)
`ifdef HAZARD_STALL_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == src) return 2'd1;
    if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic exp_stall();
    logic lu;
    lu = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == id_rs || id_ex_rt == id_rt);
    return lu || (md_left > 0 && id_md_read);
  endfunction

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (exp_stall()) exp_cnt++;
      if (md_left > 0) md_left--;
      else if (md_start) md_left = LAT - 1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, "_fwd_a"}, 32'(fwd_a_sel), 32'(exp_fwd(ex_rs)));
    check({tag, "_fwd_b"}, 32'(fwd_b_sel), 32'(exp_fwd(ex_rt)));
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall()));
    check({tag, "_flush"}, 32'(id_ex_flush), 32'(exp_stall()));
    check({tag, "_md_busy"}, 32'(md_busy), 32'(md_left > 0));
`ifdef HAZARD_STALL_STATS_EN
    check({tag, "_stall_count"}, stall_count, exp_cnt);
`endif
  endtask

  task automatic clear_inputs();
    {id_rs, id_rt, ex_rs, ex_rt, ex_mem_rd, mem_wb_rd, id_ex_rt} = '0;
    {ex_mem_reg_write, mem_wb_reg_write, id_ex_mem_read, md_start, id_md_read} = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    md_start = 1'b1;              // must be ignored while reset is held
    #2;
    check_all("reset");
    tick();
    tick();
    check_all("reset_hold");
    rst = 1'b0;
    md_start = 1'b0;
    check_all("post_reset");

    // Forwarding priority and fallback
    ex_rs = 5; ex_mem_rd = 5; ex_mem_reg_write = 1; mem_wb_rd = 5; mem_wb_reg_write = 1;
    #1 check("fwd_a_exmem_prio", 32'(fwd_a_sel), 32'd1);
    ex_mem_reg_write = 0;
    #1 check("fwd_a_memwb", 32'(fwd_a_sel), 32'd2);
    mem_wb_reg_write = 0;
    #1 check("fwd_a_none", 32'(fwd_a_sel), 32'd0);
    ex_rt = 0; ex_mem_rd = 0; ex_mem_reg_write = 1;
    #1 check("fwd_b_r0", 32'(fwd_b_sel), 32'd0);
    clear_inputs();

    // Load-use hazard
    id_ex_mem_read = 1; id_ex_rt = 8; id_rt = 8;
    #1 check("lu_stall", 32'(stall), 32'd1);
    check("lu_flush", 32'(id_ex_flush), 32'd1);
    tick();
    id_ex_mem_read = 0;
    #1 check("lu_clear_stall", 32'(stall), 32'd0);
    check("lu_clear_flush", 32'(id_ex_flush), 32'd0);
    clear_inputs();

    // Mult/div busy window
    md_start = 1; id_md_read = 1;
    #1 check("md_pre_busy", 32'(md_busy), 32'd0);
    tick();
    md_start = 0;
    for (int i = 0; i < LAT - 1; i++) begin
      #1 check($sformatf("md_busy_c%0d", i), 32'(md_busy), 32'd1);
      check($sformatf("md_stall_c%0d", i), 32'(stall), 32'd1);
      tick();
    end
    #1 check("md_done_busy", 32'(md_busy), 32'd0);
    check("md_done_stall", 32'(stall), 32'd0);
    clear_inputs();

    // Reset during the second busy cycle, then a fresh full count
    md_start = 1;
    tick();
    md_start = 0;
    #1 check("mdr_busy1", 32'(md_busy), 32'd1);
    tick();
    id_md_read = 1;
    rst = 1; md_left = 0;
    #1 check("mdr_rst_busy", 32'(md_busy), 32'd0);
    check("mdr_rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 0; md_start = 1;
    tick();
    md_start = 0;
    for (int i = 0; i < LAT - 1; i++) begin
      #1 check($sformatf("mdr_busy_c%0d", i), 32'(md_busy), 32'd1);
      tick();
    end
    #1 check("mdr_done", 32'(md_busy), 32'd0);
    clear_inputs();

`ifdef HAZARD_STALL_STATS_EN
    rst = 1; md_left = 0; exp_cnt = 0;
    tick();
    rst = 0;
    id_ex_mem_read = 1; id_ex_rt = 3; id_rs = 3;
    for (int i = 0; i < 5; i++) tick();
    id_ex_mem_read = 0;
    #1 check("stats_five", stall_count, 32'd5);
    force dut.r_stall_count = 32'hFFFF_FFFF;
    #1 release dut.r_stall_count;
    exp_cnt = 32'hFFFF_FFFF;
    id_ex_mem_read = 1;
    tick();
    id_ex_mem_read = 0;
    #1 check("stats_wrap", stall_count, 32'd0);
    exp_cnt = 0;
    clear_inputs();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_mem_rd = 5'($urandom_range(0, 3));
      mem_wb_rd = 5'($urandom_range(0, 3));
      id_ex_rt = 5'($urandom_range(0, 3));
      ex_mem_reg_write = 1'($urandom_range(0, 1));
      mem_wb_reg_write = 1'($urandom_range(0, 1));
      id_ex_mem_read = 1'($urandom_range(0, 1));
      id_md_read = 1'($urandom_range(0, 1));
      md_start = ($urandom_range(0, 7) == 0);
      check_all($sformatf("rand%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
- REQ-001 SHALL have parameter MD_LATENCY, default 32: EX cycles a mult/div occupies; legal range 2..64.
- REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
- REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
- REQ-004 SHALL have ports id_rs, id_rt  input  5 each: source registers of the instruction in ID.
- REQ-005 SHALL have ports ex_rs, ex_rt  input  5 each: source registers of the instruction in EX.
- REQ-006 SHALL have ports ex_mem_rd  input  5 and ex_mem_reg_write  input  1: EX/MEM destination register and its write enable.
- REQ-007 SHALL have ports mem_wb_rd  input  5 and mem_wb_reg_write  input  1: MEM/WB destination register and its write enable.
- REQ-008 SHALL have ports id_ex_mem_read  input  1 and id_ex_rt  input  5: the load in EX and its target register.
- REQ-009 SHALL have ports md_start  input  1 and id_md_read  input  1: a mult/div issues from EX this cycle; the ID instruction reads HI/LO or is a mult/div.
- REQ-010 SHALL have ports fwd_a_sel, fwd_b_sel  output  2 each: selects for the 3-input ALU operand muxes (0 = register file, 1 = EX/MEM, 2 = MEM/WB).
- REQ-011 SHALL have ports stall  output  1 (hold PC and IF/ID), id_ex_flush  output  1 (insert bubble into ID/EX), md_busy  output  1.

Function
- REQ-012 SHALL set fwd_a_sel to 1 when ex_mem_reg_write=1, ex_mem_rd!=0 and ex_mem_rd==ex_rs; otherwise to 2 when mem_wb_reg_write=1, mem_wb_rd!=0 and mem_wb_rd==ex_rs; otherwise to 0.
- REQ-013 SHALL compute fwd_b_sel identically from ex_rt.
- REQ-014 SHALL make the forwarding selects purely combinational with zero latency, and SHALL never drive the value 3.
- REQ-015 SHALL give EX/MEM priority over MEM/WB when both match.
- REQ-016 SHALL detect a load-use hazard when id_ex_mem_read=1, id_ex_rt!=0, and id_ex_rt equals id_rs or id_rt.
- REQ-017 SHALL run an FSM with states IDLE and MD_BUSY and a down-counter md_cnt.
- REQ-018 SHALL, in IDLE with md_start=1, load md_cnt with MD_LATENCY-1 and enter MD_BUSY on the next edge.
- REQ-019 SHALL, in MD_BUSY, decrement md_cnt each cycle and return to IDLE on the edge where md_cnt==1 (MD_LATENCY-1 cycles in MD_BUSY).
- REQ-020 SHALL ignore md_start while in MD_BUSY.
- REQ-021 SHALL drive md_busy=1 exactly when the state is MD_BUSY.
- REQ-022 SHALL assert stall and id_ex_flush combinationally in any cycle with a load-use hazard, or with md_busy=1 and id_md_read=1.
- REQ-023 SHALL assert stall and id_ex_flush once, not doubled, when the load-use and mult/div conditions coincide.
- REQ-024 SHALL not have id_ex_flush suppress the FSM count.

Reset
- REQ-025 SHALL, on rst=1 at any time including mid-MD_BUSY, immediately force state=IDLE, md_cnt=0, md_busy=0 and stall=0 (absent a load-use input condition).
- REQ-026 SHALL drive fwd_a_sel and fwd_b_sel to 0 under reset when all write enables are 0.
- REQ-027 SHALL start with a fresh full count when md_start is asserted after reset release.

Configuration
- REQ-028 SHALL, with macro HAZARD_STALL_STATS_EN defined, add port stall_count  output  32: it resets to 0, increments on every cycle with stall=1, and wraps from 0xFFFFFFFF to 0.
- REQ-029 SHALL, without HAZARD_STALL_STATS_EN, have neither the port nor the counter, and the remaining behaviour SHALL be identical.

Verification
- REQ-030 SHALL cover: ex_rs=5, ex_mem_rd=5/we=1, mem_wb_rd=5/we=1 -> fwd_a_sel=1; then ex_mem_we=0 -> fwd_a_sel=2.
- REQ-031 SHALL cover: ex_rt=0, ex_mem_rd=0/we=1 -> fwd_b_sel=0.
- REQ-032 SHALL cover: id_ex_mem_read=1, id_ex_rt=8, id_rt=8 -> stall=1 and id_ex_flush=1 in the same cycle; next cycle with id_ex_mem_read=0 -> both 0.
- REQ-033 SHALL cover: MD_LATENCY=4, md_start pulse -> md_busy=1 for exactly 3 cycles; id_md_read=1 throughout -> stall=1 for those 3 cycles.
- REQ-034 SHALL cover: rst pulsed during the 2nd MD_BUSY cycle -> md_busy=0 immediately; a new md_start then gives a full 3-cycle busy.
- REQ-035 SHALL cover: with HAZARD_STALL_STATS_EN, 5 stall cycles -> stall_count=5; preload 0xFFFFFFFF plus one stall -> stall_count=0.
